// File: rtl/score_bcd_scanner_pkg.sv
// Shared constants, types and helpers for the BCD score converter and digit scanner.
package score_bcd_scanner_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_W      = NUM_DIGITS * NIB_W;
    localparam int unsigned SR_W       = BCD_W + BIN_W;
    localparam int unsigned ITER_W     = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned MAX_VALUE  = 9999;

    localparam logic [NIB_W-1:0] BCD_BLANK = 4'hF;

    typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] bcd_digits_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } conv_state_t;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic bcd_digits_t add3_digits(bcd_digits_t d);
        bcd_digits_t r;
        r = d;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (d[i] >= NIB_W'(5)) begin
                r[i] = d[i] + NIB_W'(3);
            end
        end
        return r;
    endfunction

    function automatic logic [BIN_W-1:0] saturate(logic [BIN_W-1:0] v);
        return (v > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : v;
    endfunction

endpackage

// File: rtl/score_bcd_scanner_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one accept, 14 shifts, one latch cycle.
module bin2bcd_seq
    import score_bcd_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_t       state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    // Register layout is {bcd field, binary field}; the binary bits migrate into the BCD field.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = {BCD_W'(0), saturate(value)};
                    iter_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d   = {add3_digits(sr_q[SR_W-1:BIN_W]), sr_q[BIN_W-1:0]} << 1;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(BIN_W - 1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                bcd_d   = sr_q[SR_W-1:BIN_W];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_bcd_scanner.sv
// Score display front end: BCD conversion plus 4-digit multiplexed FND scan with leading-zero blanking.
module score_bcd_scanner
    import score_bcd_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 10000
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W-1:0]      bcd,
    output logic [NIB_W-1:0]      scan_bcd,
    output logic [NUM_DIGITS-1:0] digit_com
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0]      scan_cnt_q;
    logic [IDX_W-1:0]      idx_q;
    bcd_digits_t           digits;
    logic [NUM_DIGITS-1:0] blank;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Free-running scan timebase; the digit index steps once per SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_q + IDX_W'(1);
        end else begin
            scan_cnt_q <= scan_cnt_q + CNT_W'(1);
        end
    end

    // A digit is blank when it and every more-significant digit are zero; ones is always shown.
    always_comb begin
        logic zero_run;
        digits   = bcd;
        blank    = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (digits[i] == NIB_W'(0));
            blank[i] = zero_run;
        end
    end

    assign scan_bcd  = blank[idx_q] ? BCD_BLANK : digits[idx_q];
    assign digit_com = ~(NUM_DIGITS'(1) << idx_q);

endmodule

// File: tb/tb_score_bcd_scanner.sv
// Randomized scoreboard bench for score_bcd_scanner against an arithmetic reference model.
module tb_score_bcd_scanner;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  scan_bcd;
    logic [3:0]  digit_com;

    score_bcd_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .scan_bcd  (scan_bcd),
        .digit_com (digit_com)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        int at_edge;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int cyc = 0;
    int scyc = 0;
    int next_accept = 0;
    int last_accept = -100;
    int pend_val = 0;
    int pend_edge = -1;
    int disp = 0;

    function automatic int pow10(int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic int to_bcd(int v);
        int r = 0;
        for (int i = 0; i < 4; i++) r = r + (((v / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    function automatic int exp_scan(int v, int i);
        if (i > 0 && v < pow10(i)) return 15;
        return (v / pow10(i)) % 10;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: acceptance, conversion timing and displayed value, sampled at the active edge
    always @(posedge clk) begin
        int v;
        cyc++;
        if (rst_n) begin
            scyc++;
            if (cyc == pend_edge) disp = pend_val;
            if (start && cyc >= next_accept) begin
                v = (int'(value) > 9999) ? 9999 : int'(value);
                sb.push_back('{v, cyc + 15});
                pend_val    = v;
                pend_edge   = cyc + 15;
                next_accept = cyc + 16;
                last_accept = cyc;
            end
        end
    end

    // Monitor: compare DUT outputs on the falling edge
    always @(negedge clk) begin
        exp_t e;
        int idx;
        if (!rst_n) begin
            chk("rst_bcd", int'(bcd), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_digit_com", int'(digit_com), 4'b1110);
            chk("rst_scan_bcd", int'(scan_bcd), 0);
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done at edge %0d: got done=1 expected no done", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_edge", cyc, e.at_edge);
                    chk("done_bcd", int'(bcd), to_bcd(e.val));
                end
            end
            if (sb.size() > 0 && cyc > sb[0].at_edge) begin
                checks++;
                errors++;
                $display("FAIL missing_done at edge %0d: got none expected at edge %0d", cyc, sb[0].at_edge);
                void'(sb.pop_front());
            end
            chk("done_level", int'(done), (cyc == pend_edge) ? 1 : 0);
            chk("busy", int'(busy), (cyc >= last_accept && cyc <= last_accept + 14) ? 1 : 0);
            chk("bcd_held", int'(bcd), to_bcd(disp));
            idx = (scyc / SCAN_DIV) % 4;
            chk("digit_com", int'(digit_com), 15 - (1 << idx));
            chk("scan_bcd", int'(scan_bcd), exp_scan(disp, idx));
        end
    end

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        sb.delete();
        next_accept = 0;
        last_accept = -100;
        pend_edge   = -1;
        pend_val    = 0;
        disp        = 0;
        scyc        = 0;
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic conv(input int v, input int pulse, input int gap);
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 14'(v);
        repeat (pulse) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed values including saturation, zero and internal zeros
        conv(1234, 1, 32);
        conv(9999, 1, 32);
        conv(12000, 1, 32);
        conv(0, 1, 32);
        conv(7, 1, 32);
        conv(1005, 1, 32);

        // Reset mid-scan
        repeat (6) @(posedge clk);
        do_reset(3);
        repeat (20) @(posedge clk);

        // Start held high with a new value every cycle
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            value = 14'($urandom_range(0, 16383));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        // Abort during iteration 7, then a clean conversion of the same value
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 14'(4321);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        do_reset(2);
        conv(4321, 1, 20);

        // Random pulses and gaps, including starts that land while busy
        for (int i = 0; i < 40; i++) begin
            conv(($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                             : int'($urandom_range(0, 9999)),
                 int'($urandom_range(1, 3)), int'($urandom_range(0, 20)));
        end

        start = 1'b0;
        repeat (40) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
